present_decryptor_top: RTL and testbench

Single-clock PRESENT-80 decryption core, the inverse of the team's `present_encryptor_top`, sharing its load-style input interface. A loaded 80-bit key is expanded forward once to the final round key K32, which is retained. Each loaded 64-bit ciphertext is then decrypted in 31 iterative inverse rounds, walking the key schedule backwards. Intended to sit beside the encryptor so the team has a loop-back encrypt/decrypt pair.

---
 rtl/present_pkg.sv | 67 ++++++
 rtl/present_key_schedule.sv | 35 +++
 rtl/present_decryptor_top.sv | 135 +++++++++++++
 tb/tb_present_decryptor_top.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions for the encryptor/decryptor pair.
// Holds the 4-bit S-box tables, the 64-bit substitution and permutation
// layers (forward and inverse), the core FSM state type, the key-schedule
// direction type and the datapath widths.
package present_pkg;

  localparam int unsigned ROUNDS  = 31;
  localparam int unsigned KEY_W   = 80;
  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned CTR_W   = 5;

  // Nibble n of each table is S(n) / S^-1(n).
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    ST_NOKEY  = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2,
    ST_ROUNDS = 2'd3
  } state_e;

  typedef enum logic {
    KS_FWD = 1'b0,
    KS_INV = 1'b1
  } ks_mode_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox64(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox4(s[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] inv_sbox64(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox4(s[4*n +: 4]);
    return r;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[(16 * i) % 63] = s[i];
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[i] = s[(16 * i) % 63];
    r[63] = s[63];
    return r;
  endfunction

endpackage

// File: rtl/present_key_schedule.sv
// Combinational one-step PRESENT-80 key update, either direction.
//   mode     : KS_FWD computes K(c+1) from K(c); KS_INV computes K(c) from K(c+1)
//   key      : 80-bit input key register value
//   ctr      : 5-bit round counter c
//   next_key : updated 80-bit key
module present_key_schedule
  import present_pkg::*;
(
  input  ks_mode_e           mode,
  input  logic [KEY_W-1:0]   key,
  input  logic [CTR_W-1:0]   ctr,
  output logic [KEY_W-1:0]   next_key
);

  logic [KEY_W-1:0] fwd_c;
  logic [KEY_W-1:0] inv_c;

  // Forward: rotate left 61, S-box top nibble, fold in counter.
  always_comb begin
    fwd_c          = {key[18:0], key[79:19]};
    fwd_c[79:76]   = sbox4(fwd_c[79:76]);
    fwd_c[19:15]   = fwd_c[19:15] ^ ctr;
  end

  // Inverse: undo the three forward steps in reverse order.
  always_comb begin
    inv_c          = key;
    inv_c[19:15]   = inv_c[19:15] ^ ctr;
    inv_c[79:76]   = inv_sbox4(inv_c[79:76]);
    inv_c          = {inv_c[60:0], inv_c[79:61]};
  end

  assign next_key = (mode == KS_INV) ? inv_c : fwd_c;

endmodule

// File: rtl/present_decryptor_top.sv
// PRESENT-80 iterative decryption core.
// A loaded key is expanded forward to K32 once (31 cycles) and retained;
// each accepted ciphertext is then decrypted in 31 inverse rounds while the
// key schedule is walked backwards from K32.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   data_i    : key (80 bits) on key_load, ciphertext (bits 63:0) on data_load
//   key_load  : strobe, capture new key and start expansion (any state)
//   data_load : strobe, capture ciphertext and start decryption (READY only)
//   data_o    : plaintext of the last completed decryption
//   ready_o   : key expanded and core idle
//   valid_o   : data_o belongs to the most recently accepted ciphertext
module present_decryptor_top
  import present_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [KEY_W-1:0]   data_i,
  input  logic               key_load,
  input  logic               data_load,
  output logic [BLOCK_W-1:0] data_o,
  output logic               ready_o,
  output logic               valid_o
);

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   k_q, k_d;
  logic [KEY_W-1:0]   wk_q, wk_d;
  logic [KEY_W-1:0]   k32_q, k32_d;
  logic [BLOCK_W-1:0] s_q, s_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [BLOCK_W-1:0] data_d;
  logic               ready_d;
  logic               valid_d;

  ks_mode_e           ks_mode;
  logic [KEY_W-1:0]   ks_key;
  logic [KEY_W-1:0]   ks_next;

  // One key-schedule step shared by expansion (forward on K) and rounds
  // (inverse on WK).
  assign ks_mode = (state_q == ST_ROUNDS) ? KS_INV : KS_FWD;
  assign ks_key  = (state_q == ST_ROUNDS) ? wk_q : k_q;

  present_key_schedule u_key_schedule (
    .mode     (ks_mode),
    .key      (ks_key),
    .ctr      (ctr_q),
    .next_key (ks_next)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wk_d    = wk_q;
    k32_d   = k32_q;
    s_d     = s_q;
    ctr_d   = ctr_q;
    data_d  = data_o;
    ready_d = ready_o;
    valid_d = valid_o;

    if (key_load) begin
      // Wins over data_load and aborts any decryption in flight.
      k_d     = data_i;
      ctr_d   = CTR_W'(1);
      valid_d = 1'b0;
      ready_d = 1'b0;
      state_d = ST_EXPAND;
    end else begin
      case (state_q)
        ST_EXPAND: begin
          k_d = ks_next;
          if (ctr_q == CTR_W'(ROUNDS)) begin
            k32_d   = ks_next;
            ready_d = 1'b1;
            state_d = ST_READY;
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
        ST_READY: begin
          if (data_load) begin
            s_d     = data_i[BLOCK_W-1:0] ^ k32_q[79:16];
            wk_d    = k32_q;
            ctr_d   = CTR_W'(ROUNDS);
            valid_d = 1'b0;
            ready_d = 1'b0;
            state_d = ST_ROUNDS;
          end
        end
        ST_ROUNDS: begin
          s_d  = inv_sbox64(inv_p_layer(s_q)) ^ ks_next[79:16];
          wk_d = ks_next;
          if (ctr_q == CTR_W'(1)) begin
            data_d  = s_d;
            valid_d = 1'b1;
            ready_d = 1'b1;
            state_d = ST_READY;
          end else begin
            ctr_d = ctr_q - CTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_NOKEY;
      k_q     <= '0;
      wk_q    <= '0;
      k32_q   <= '0;
      s_q     <= '0;
      ctr_q   <= '0;
      data_o  <= '0;
      ready_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wk_q    <= wk_d;
      k32_q   <= k32_d;
      s_q     <= s_d;
      ctr_q   <= ctr_d;
      data_o  <= data_d;
      ready_o <= ready_d;
      valid_o <= valid_d;
    end
  end

endmodule

// File: tb/tb_present_decryptor_top.sv
// Self-checking bench for present_decryptor_top: published PRESENT-80
// vectors, load/abort/reset corner cases, and a loop-back run against an
// independent encryption model.
module tb_present_decryptor_top;

  logic        clk_i;
  logic        rst_ni;
  logic [79:0] data_i;
  logic        key_load;
  logic        data_load;
  logic [63:0] data_o;
  logic        ready_o;
  logic        valid_o;

  int vectors;
  int miscompares;
  logic [63:0] sb[$];

  typedef struct {
    logic [79:0] key;
    logic [63:0] ct;
    logic [63:0] pt;
    logic        reload;
    int          poke;
  } vec_t;

  vec_t vecs[4];

  present_decryptor_top dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .data_i    (data_i),
    .key_load  (key_load),
    .data_load (data_load),
    .data_o    (data_o),
    .ready_o   (ready_o),
    .valid_o   (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encryption model.
  function automatic logic [3:0] m_s4(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] m_encrypt(input logic [79:0] key, input logic [63:0] pt);
    logic [79:0] k;
    logic [63:0] s;
    logic [63:0] t;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = m_s4(s[4*n +: 4]);
      for (int b = 0; b < 64; b++) s[(b == 63) ? 63 : (b * 16) % 63] = t[b];
      k = {k[18:0], k[79:19]};
      k[79:76] = m_s4(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Count cycles from the key_load edge until ready_o; optionally pulse
  // data_load at cycle poke_at of the expansion.
  task automatic wait_ready(input string name, input int poke_at);
    int n;
    logic saw_valid;
    n = 1;
    saw_valid = 1'b0;
    while (!ready_o && n < 40) begin
      if (valid_o) saw_valid = 1'b1;
      data_load = (n == poke_at);
      @(negedge clk_i);
      n++;
    end
    data_load = 1'b0;
    check({name, "_expand_latency"}, 80'(n), 80'd32);
    check({name, "_valid_low"}, 80'(saw_valid), 80'd0);
  endtask

  task automatic load_key(input string name, input logic [79:0] key,
                          input logic with_data, input int poke_at);
    data_i    = key;
    key_load  = 1'b1;
    data_load = with_data;
    @(posedge clk_i);
    @(negedge clk_i);
    key_load  = 1'b0;
    data_load = 1'b0;
    wait_ready(name, poke_at);
  endtask

  task automatic start_data(input logic [63:0] ct, input logic [63:0] pt);
    sb.push_back(pt);
    data_i    = {16'hA5C3, ct};
    data_load = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    data_load = 1'b0;
  endtask

  task automatic decrypt(input string name, input logic [63:0] ct, input logic [63:0] pt);
    int n;
    logic early;
    logic [63:0] exp;
    start_data(ct, pt);
    n = 1;
    early = 1'b0;
    while (!valid_o && n < 40) begin
      if (ready_o) early = 1'b1;
      @(negedge clk_i);
      n++;
    end
    check({name, "_latency"}, 80'(n), 80'd32);
    check({name, "_ready_busy"}, 80'(early), 80'd0);
    check({name, "_ready_done"}, 80'(ready_o), 80'd1);
    if (sb.size() == 0) begin
      check({name, "_scoreboard_empty"}, 80'd1, 80'd0);
    end else begin
      exp = sb.pop_front();
      check({name, "_plaintext"}, 80'(data_o), 80'(exp));
    end
  endtask

  initial begin
    logic [63:0] prev;
    logic [79:0] key;
    logic [63:0] pt;
    logic [31:0] r0, r1, r2, r3;

    vectors     = 0;
    miscompares = 0;
    rst_ni      = 1'b0;
    key_load    = 1'b0;
    data_load   = 1'b0;
    data_i      = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    check("reset_data", 80'(data_o), 80'd0);
    check("reset_ready", 80'(ready_o), 80'd0);
    check("reset_valid", 80'(valid_o), 80'd0);

    // Published vectors; the last one also pokes data_load during EXPAND.
    vecs[0] = '{80'h0, 64'h5579c1387b228445, 64'h0000000000000000, 1'b1, 0};
    vecs[1] = '{{80{1'b1}}, 64'he72c46c0f5945049, 64'h0000000000000000, 1'b1, 0};
    vecs[2] = '{{80{1'b1}}, 64'h3333dcd3213210d2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0};
    vecs[3] = '{80'h0, 64'ha112ffc72f68417b, 64'hFFFFFFFFFFFFFFFF, 1'b1, 5};
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].reload) load_key($sformatf("vec%0d", i), vecs[i].key, 1'b0, vecs[i].poke);
      decrypt($sformatf("vec%0d", i), vecs[i].ct, vecs[i].pt);
    end

    // key_load together with data_load: the key wins, no decryption starts.
    load_key("collide", {80{1'b1}}, 1'b1, 0);
    check("collide_valid", 80'(valid_o), 80'd0);
    decrypt("collide", 64'h3333dcd3213210d2, 64'hFFFFFFFFFFFFFFFF);

    // key_load at D+10 aborts the decryption and keeps the old plaintext.
    prev = data_o;
    start_data(64'he72c46c0f5945049, 64'h0);
    repeat (9) @(negedge clk_i);
    data_i   = 80'h0;
    key_load = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    key_load = 1'b0;
    void'(sb.pop_back());
    check("abort_valid", 80'(valid_o), 80'd0);
    check("abort_data", 80'(data_o), 80'(prev));
    check("abort_ready", 80'(ready_o), 80'd0);
    wait_ready("abort", 0);
    check("abort_data_kept", 80'(data_o), 80'(prev));
    decrypt("after_abort", 64'h5579c1387b228445, 64'h0);

    // Reset at D+10, then a data_load with no key must be ignored.
    decrypt("pre_reset", 64'ha112ffc72f68417b, 64'hFFFFFFFFFFFFFFFF);
    start_data(64'h5579c1387b228445, 64'h0);
    repeat (9) @(negedge clk_i);
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    sb.delete();
    check("rst_mid_data", 80'(data_o), 80'd0);
    check("rst_mid_ready", 80'(ready_o), 80'd0);
    check("rst_mid_valid", 80'(valid_o), 80'd0);
    data_i    = {16'h0, 64'h5579c1387b228445};
    data_load = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    data_load = 1'b0;
    repeat (40) @(negedge clk_i);
    check("nokey_valid", 80'(valid_o), 80'd0);
    check("nokey_ready", 80'(ready_o), 80'd0);
    check("nokey_data", 80'(data_o), 80'd0);

    // Loop-back against the encryption model.
    key = '0;
    for (int v = 0; v < 1000; v++) begin
      if (v % 16 == 0) begin
        r0 = $urandom;
        r1 = $urandom;
        r2 = $urandom;
        key = {16'(r2), r1, r0};
        load_key($sformatf("lb_key%0d", v), key, 1'b0, 0);
      end
      r0 = $urandom;
      r3 = $urandom;
      pt = {r3, r0};
      decrypt($sformatf("lb%0d", v), m_encrypt(key, pt), pt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
